mm_pipe_bridge: RTL and testbench
=================================

Name: mm_pipe_bridge

Overview:
- Registered Avalon-MM pipeline bridge between the virtual-JTAG master and the SDRAM controller slave, carrying address, read, write, writedata and byteenable.
- Breaks the combinational command and response paths with a one-entry command slice and a registered read-response stage.
- Limits outstanding reads to MAX_PENDING and flags unsolicited read data.
- Exposes transaction counters for the board LEDs.

Parameters:
- ADDR_BITS, 32, width of the address on both sides.
- DATA_BITS, 32, width of the data on both sides; byteenable width is DATA_BITS/8.
- MAX_PENDING, 4, maximum accepted but unreturned reads; range 1..15.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset.
- s_address  in  ADDR_BITS  upstream command address.
- s_read  in  1  upstream read request.
- s_write  in  1  upstream write request.
- s_writedata  in  DATA_BITS  upstream write data.
- s_byteenable  in  DATA_BITS/8  upstream byte enables, active-high.
- s_waitrequest  out  1  stall to upstream.
- s_readdata  out  DATA_BITS  read data to upstream.
- s_readdatavalid  out  1  read data valid to upstream.
- m_address  out  ADDR_BITS  command address to the SDRAM side.
- m_read  out  1  read request to the SDRAM side.
- m_write  out  1  write request to the SDRAM side.
- m_writedata  out  DATA_BITS  write data to the SDRAM side.
- m_byteenable  out  DATA_BITS/8  byte enables to the SDRAM side, active-high.
- m_waitrequest  in  1  stall from the SDRAM side.
- m_readdata  in  DATA_BITS  read data from the SDRAM side.
- m_readdatavalid  in  1  read data valid from the SDRAM side.
- pending  out  4  current count of outstanding reads.
- rd_count  out  8  reads completed (response delivered upstream), wraps at 256.
- wr_count  out  8  writes issued downstream, wraps at 256.
- err  out  1  sticky flag: m_readdatavalid seen while pending==0.

Behaviour:
- Reset (rst low, asynchronous): command slice empty; m_read=0, m_write=0; m_address, m_writedata, m_byteenable=0; s_readdatavalid=0; s_readdata=0; pending=0; rd_count=0; wr_count=0; err=0.
- Command slice holds one command. States: EMPTY, FULL.
  - m_read/m_write reflect the held command and are 0 when EMPTY.
  - Downstream accept = FULL & !m_waitrequest.
- Upstream accept = (s_read|s_write) & !s_waitrequest.
  - s_waitrequest = FULL & m_waitrequest, OR (s_read & credit exhausted).
  - The comb path m_waitrequest -> s_waitrequest is intentional.
  - Credit exhausted: pending + held_read ≥ MAX_PENDING, where held_read=1 if the slice holds a read.
- Transitions:
  - EMPTY + upstream accept -> FULL, command loaded.
  - FULL + downstream accept + upstream accept -> FULL, new command loaded in the same cycle (back-to-back, 1 command/cycle).
  - FULL + downstream accept only -> EMPTY.
  - Otherwise the slice holds.
- Command latency: a command accepted at edge N is presented on m_* from cycle N+1.
- s_read and s_write both high: write has priority. The read is not accepted and must be re-presented.
- pending:
  - +1 when a read is accepted downstream.
  - −1 when m_readdatavalid.
  - Unchanged when both occur in the same cycle.
  - Never decrements below 0; if m_readdatavalid arrives with pending==0, err is set and the data is still forwarded.
- Response stage: s_readdata/s_readdatavalid are registered copies of m_readdata/m_readdatavalid (1-cycle latency). There is no backpressure upstream.
- rd_count increments on each cycle with s_readdatavalid=1.
- wr_count increments on each downstream write accept.
- Both counters wrap 255->0.
- err clears only on reset.
- Reset mid-transaction: the held command is dropped, in-flight reads are forgotten, and late m_readdatavalid after reset sets err.

Test Plan:
- Single write: s_write=1, addr 0x100, data 0xDEADBEEF, be 0xF, m_waitrequest=0 -> m_write=1 with identical fields next cycle for 1 cycle; wr_count=1; s_waitrequest stays 0.
- Back-to-back writes: 8 consecutive writes with m_waitrequest=0 -> 8 consecutive m_write cycles, no upstream stall, wr_count=8.
- Backpressure: m_waitrequest=1 for 5 cycles while FULL -> s_waitrequest=1 for those cycles; m_* fields stable; command is issued on the cycle m_waitrequest drops.
- Read credit limit: MAX_PENDING=4, continuous reads, no m_readdatavalid -> 4 reads issued downstream, then s_waitrequest=1. Return one word 0x12345678 -> s_readdatavalid=1, s_readdata=0x12345678 one cycle later; the fifth read is issued; rd_count=1.
- Simultaneous issue/return: pending=2, a read accepted downstream in the same cycle as m_readdatavalid -> pending stays 2.
- Error and reset: m_readdatavalid with pending=0 -> err=1, data forwarded. Drive rst low mid-write -> all outputs return to reset values immediately, err=0.

Source files
------------

// File: rtl/mm_pipe_bridge_if.sv
// Avalon-MM command/response bundle shared by both sides of the pipeline bridge.
// The master side drives the command; the slave side drives waitrequest and read data.
interface mm_pipe_bridge_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);
  localparam int BE_BITS = DATA_BITS / 8;

  logic [ADDR_BITS-1:0] address;
  logic                 read;
  logic                 write;
  logic [DATA_BITS-1:0] writedata;
  logic [BE_BITS-1:0]   byteenable;
  logic                 waitrequest;
  logic [DATA_BITS-1:0] readdata;
  logic                 readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/mm_pipe_bridge.sv
// Registered Avalon-MM bridge: one-entry command slice (1 cycle) and registered read response (1 cycle).
// Upstream stalls while the slice is blocked downstream or read credit is exhausted; responses have no backpressure.
module mm_pipe_bridge #(
  parameter int ADDR_BITS   = 32,
  parameter int DATA_BITS   = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  mm_pipe_bridge_if.slave   s,
  mm_pipe_bridge_if.master  m,
  output logic [3:0]        pending,
  output logic [7:0]        rd_count,
  output logic [7:0]        wr_count,
  output logic              err
);
  localparam int BE_BITS = DATA_BITS / 8;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic [BE_BITS-1:0]   be;
    logic                 is_rd;
    logic                 is_wr;
  } cmd_t;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t     state_q, state_d;
  cmd_t       cmd_q, cmd_d, cmd_new;
  logic       full;
  logic       held_read;
  logic [4:0] credit_used;
  logic       credit_exh;
  logic       up_acc;
  logic       dn_acc;
  logic       rd_issue;

  assign full        = (state_q == S_FULL);
  assign held_read   = full & cmd_q.is_rd;
  assign credit_used = {1'b0, pending} + {4'd0, held_read};
  assign credit_exh  = (credit_used >= 5'(MAX_PENDING));

  // m_waitrequest reaches s_waitrequest combinationally so the slice can refill on the issue cycle.
  assign s.waitrequest = (full & m.waitrequest) | (s.read & credit_exh);
  assign up_acc        = (s.read | s.write) & ~s.waitrequest;
  assign dn_acc        = full & ~m.waitrequest;
  assign rd_issue      = dn_acc & cmd_q.is_rd;

  // Write wins when both strobes are high; the read must be presented again.
  always_comb begin
    cmd_new       = '0;
    cmd_new.addr  = s.address;
    cmd_new.wdata = s.writedata;
    cmd_new.be    = s.byteenable;
    cmd_new.is_wr = s.write;
    cmd_new.is_rd = s.read & ~s.write;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      S_EMPTY: begin
        if (up_acc) begin
          state_d = S_FULL;
          cmd_d   = cmd_new;
        end
      end
      S_FULL: begin
        if (up_acc) begin
          cmd_d = cmd_new;
        end else if (dn_acc) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  assign m.address    = cmd_q.addr;
  assign m.writedata  = cmd_q.wdata;
  assign m.byteenable = cmd_q.be;
  assign m.read       = full & cmd_q.is_rd;
  assign m.write      = full & cmd_q.is_wr;

  // Unsolicited data is still forwarded; it only raises the sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 4'd0;
      err     <= 1'b0;
    end else begin
      unique case ({rd_issue, m.readdatavalid})
        2'b10:   pending <= pending + 4'd1;
        2'b01:   if (pending != 4'd0) pending <= pending - 4'd1;
        default: pending <= pending;
      endcase
      if (m.readdatavalid && (pending == 4'd0)) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s.readdata      <= '0;
      s.readdatavalid <= 1'b0;
    end else begin
      s.readdata      <= m.readdata;
      s.readdatavalid <= m.readdatavalid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= 8'd0;
      wr_count <= 8'd0;
    end else begin
      if (s.readdatavalid) begin
        rd_count <= rd_count + 8'd1;
      end
      if (dn_acc && cmd_q.is_wr) begin
        wr_count <= wr_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_mm_pipe_bridge.sv
// Self-checking bench for mm_pipe_bridge: vector table for single commands, scoreboards for
// downstream commands and upstream read responses, and hand sequences for the multi-cycle cases.
module tb_mm_pipe_bridge;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mm_pipe_bridge_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) up ();
  mm_pipe_bridge_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) dn ();

  logic [3:0] pending;
  logic [7:0] rd_count;
  logic [7:0] wr_count;
  logic       err;

  mm_pipe_bridge #(.ADDR_BITS(AW), .DATA_BITS(DW), .MAX_PENDING(MAXP)) dut (
    .clk      (clk),
    .rst      (rst),
    .s        (up),
    .m        (dn),
    .pending  (pending),
    .rd_count (rd_count),
    .wr_count (wr_count),
    .err      (err)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
  } cmd_exp_t;

  typedef struct {
    logic [31:0] d;
    int          cyc;
  } rsp_exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        exp_rd;
    logic        exp_wr;
    int          exp_stall;
  } vec_t;

  cmd_exp_t cmd_q[$];
  rsp_exp_t rsp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller is just after a rising edge; returns just after the edge that accepted the command.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic erd, input logic ewr, input int budget,
                       output int stalls);
    up.read = rd; up.write = wr; up.address = a; up.writedata = d; up.byteenable = be;
    stalls = 0;
    @(negedge clk);
    while (up.waitrequest && stalls < budget) begin
      stalls++;
      @(negedge clk);
    end
    if (up.waitrequest) begin
      checks++; errors++;
      $display("FAIL issue_timeout: s_waitrequest still 1 after %0d cycles, expected 0", stalls);
    end else begin
      cmd_q.push_back('{a, d, be, erd, ewr});
    end
    @(posedge clk); #1;
    up.read = 1'b0; up.write = 1'b0;
  endtask

  // One cycle of downstream read data; the upstream copy is due one cycle later.
  task automatic ret(input logic [31:0] d);
    dn.readdatavalid = 1'b1; dn.readdata = d;
    rsp_q.push_back('{d, cyc + 1});
    @(posedge clk); #1;
    dn.readdatavalid = 1'b0; dn.readdata = '0;
  endtask

  always @(negedge clk) begin
    cmd_exp_t ce;
    rsp_exp_t re;
    if (rst) begin
      if ((dn.read || dn.write) && !dn.waitrequest) begin
        if (cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dn_unexpected_cmd: got addr 0x%0h with no command outstanding", dn.address);
        end else begin
          ce = cmd_q.pop_front();
          chk("dn_addr", dn.address, ce.a);
          chk("dn_wdata", dn.writedata, ce.d);
          chk("dn_be", dn.byteenable, ce.be);
          chk("dn_read", dn.read, ce.rd);
          chk("dn_write", dn.write, ce.wr);
        end
      end
      if (up.readdatavalid) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL up_unexpected_rsp: got data 0x%0h with no response outstanding", up.readdata);
        end else begin
          re = rsp_q.pop_front();
          chk("up_rdata", up.readdata, re.d);
          chk("up_rsp_cycle", cyc, re.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   st;
    int   st_b;
    int   rstall[5];
    int   n;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0001, 4'hF, 1'b0, 1'b1, 0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_1004, 32'h1111_2222, 4'h1, 1'b0, 1'b1, 0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_1008, 32'h3333_4444, 4'h2, 1'b0, 1'b1, 0};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_100C, 32'h5555_6666, 4'h4, 1'b0, 1'b1, 0};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_1010, 32'h7777_8888, 4'h8, 1'b0, 1'b1, 0};
    vecs[5] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hC, 1'b0, 1'b1, 0};
    vecs[6] = '{1'b0, 1'b1, 32'h8000_0000, 32'hA5A5_5A5A, 4'h3, 1'b0, 1'b1, 0};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 0};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_2000, 32'hBEEF_0001, 4'hF, 1'b0, 1'b1, 0};

    up.read = 1'b0; up.write = 1'b0; up.address = '0; up.writedata = '0; up.byteenable = '0;
    dn.waitrequest = 1'b0; dn.readdata = '0; dn.readdatavalid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_read", dn.read, 0);
    chk("rst_m_write", dn.write, 0);
    chk("rst_m_addr", dn.address, 0);
    chk("rst_m_wdata", dn.writedata, 0);
    chk("rst_m_be", dn.byteenable, 0);
    chk("rst_s_rdv", up.readdatavalid, 0);
    chk("rst_s_rdata", up.readdata, 0);
    chk("rst_s_wait", up.waitrequest, 0);
    chk("rst_pending", pending, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single write
    issue(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 5, st);
    chk("single_stall", st, 0);
    @(posedge clk); #1;
    chk("single_m_write_off", dn.write, 0);
    chk("single_wr_count", wr_count, 1);
    chk("single_s_wait", up.waitrequest, 0);

    // Back-to-back table, including write priority over a simultaneous read
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].be,
            vecs[i].exp_rd, vecs[i].exp_wr, 5, st);
      chk("vec_stall", st, vecs[i].exp_stall);
    end
    @(posedge clk); #1;
    chk("b2b_wr_count", wr_count, 10);
    chk("b2b_pending", pending, 0);

    // Backpressure: 5 stalled cycles while the slice holds write A
    dn.waitrequest = 1'b1;
    issue(1'b0, 1'b1, 32'h0000_0A00, 32'h0A0A_0A0A, 4'hF, 1'b0, 1'b1, 5, st);
    fork
      issue(1'b0, 1'b1, 32'h0000_0B00, 32'h0B0B_0B0B, 4'h5, 1'b0, 1'b1, 20, st_b);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_s_wait", up.waitrequest, 1);
          chk("bp_m_addr", dn.address, 32'h0000_0A00);
          chk("bp_m_write", dn.write, 1);
        end
        @(posedge clk); #1;
        dn.waitrequest = 1'b0;
      end
    join
    chk("bp_stall_cycles", st_b, 5);
    @(posedge clk); #1;
    chk("bp_wr_count", wr_count, 12);

    // Read credit limit
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          issue(1'b1, 1'b0, 32'h200 + 32'(i), 32'h0, 4'hF, 1'b1, 1'b0, 40, rstall[i]);
        end
      end
      begin
        n = 0;
        @(negedge clk);
        while (pending != 4'd4 && n < 40) begin
          @(negedge clk);
          n++;
        end
        chk("credit_pending", pending, 4);
        repeat (2) begin
          chk("credit_s_wait", up.waitrequest, 1);
          @(negedge clk);
        end
        @(posedge clk); #1;
        ret(32'h1234_5678);
      end
    join
    for (int i = 0; i < 4; i++) chk("credit_no_stall", rstall[i], 0);
    chk("credit_r5_stalled", (rstall[4] > 0), 1);
    @(posedge clk); #1;
    chk("credit_pending_after", pending, 4);
    chk("credit_rd_count", rd_count, 1);
    for (int i = 0; i < 4; i++) ret(32'hA000_0000 + 32'(i));
    repeat (2) begin @(posedge clk); #1; end
    chk("drain_pending", pending, 0);
    chk("drain_rd_count", rd_count, 5);

    // Read issued downstream in the same cycle as returned data
    for (int i = 0; i < 3; i++) issue(1'b1, 1'b0, 32'h300 + 32'(i), 32'h0, 4'hF, 1'b1, 1'b0, 5, st);
    dn.readdatavalid = 1'b1; dn.readdata = 32'h55AA_55AA;
    rsp_q.push_back('{32'h55AA_55AA, cyc + 1});
    @(negedge clk);
    chk("sim_pending_before", pending, 2);
    chk("sim_read_issuing", dn.read & ~dn.waitrequest, 1);
    @(posedge clk); #1;
    dn.readdatavalid = 1'b0;
    chk("sim_pending_after", pending, 2);
    ret(32'h0000_0001);
    ret(32'h0000_0002);
    repeat (2) begin @(posedge clk); #1; end
    chk("sim_drain_pending", pending, 0);
    chk("sim_rd_count", rd_count, 8);
    chk("sim_err_clear", err, 0);

    // Unsolicited read data
    ret(32'hCAFE_F00D);
    @(posedge clk); #1;
    chk("unsol_err", err, 1);
    chk("unsol_pending", pending, 0);
    chk("unsol_rd_count", rd_count, 9);

    // Reset while a write is held in the slice
    dn.waitrequest = 1'b1;
    issue(1'b0, 1'b1, 32'h400, 32'h4444_4444, 4'hF, 1'b0, 1'b1, 5, st);
    #2 rst = 1'b0;
    #1;
    cmd_q.delete();
    chk("mid_rst_m_write", dn.write, 0);
    chk("mid_rst_m_addr", dn.address, 0);
    chk("mid_rst_m_wdata", dn.writedata, 0);
    chk("mid_rst_m_be", dn.byteenable, 0);
    chk("mid_rst_s_wait", up.waitrequest, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_wr_count", wr_count, 0);
    chk("mid_rst_rd_count", rd_count, 0);
    chk("mid_rst_pending", pending, 0);
    dn.waitrequest = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    ret(32'h0BAD_F00D);
    @(posedge clk); #1;
    chk("late_rdv_err", err, 1);
    chk("late_rdv_rd_count", rd_count, 1);
    chk("cmd_sb_empty", cmd_q.size(), 0);
    chk("rsp_sb_empty", rsp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
